// File: rtl/mips_fetch_stage_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// No logic; latency and backpressure not applicable.
package mips_fetch_stage_pkg;
    localparam int unsigned INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    typedef struct packed {
        logic [31:0]        pc_plus4;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{pc_plus4: 32'h0, instr: NOP, valid: 1'b0};

    // J/JAL keep the top nibble of the delay-slot PC (PC+4 of the jump itself).
    function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [25:0] idx);
        return {pc4[31:28], idx, 2'b00};
    endfunction
endpackage

// File: rtl/mips_fetch_stage_if.sv
// Fetch-stage bus: control inputs from ID/EX, instruction memory and IF/ID outputs.
// Latency: wires only; backpressure: stall and redirects are sampled by the fetch stage.
interface mips_fetch_stage_if;
    import mips_fetch_stage_pkg::*;

    logic               stall;
    logic               branch_taken;
    logic [31:0]        branch_target;
    logic               jump;
    logic [25:0]        jump_index;
    logic               halt_req;
    logic [31:0]        imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [31:0]        ifid_pc_plus4;
    logic [INSTR_W-1:0] ifid_instr;
    logic               ifid_valid;
    logic [31:0]        fetch_count;
    logic               halted;
    logic               misalign_err;

    modport master (
        input  stall, branch_taken, branch_target, jump, jump_index, halt_req, imem_rdata,
        output imem_addr, ifid_pc_plus4, ifid_instr, ifid_valid, fetch_count, halted, misalign_err
    );

    modport slave (
        output stall, branch_taken, branch_target, jump, jump_index, halt_req, imem_rdata,
        input  imem_addr, ifid_pc_plus4, ifid_instr, ifid_valid, fetch_count, halted, misalign_err
    );
endinterface

// File: rtl/mips_fetch_stage_pc_incrementer.sv
// 32-bit combinational adder producing PC+4; wraps modulo 2^32, no carry-out.
// Latency: 0 cycles; backpressure: none.
module pc_incrementer (
    input  logic [31:0] in1_i,
    input  logic [31:0] in2_i,
    output logic [31:0] sum_o
);
    assign sum_o = in1_i + in2_i;
endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS IF stage: PC, next-PC select, IF/ID register, halt FSM, fetch counter.
// Latency: instruction in IF/ID one edge after its PC; backpressure: stall holds PC/IF/ID, redirects override it.
module mips_fetch_stage
    import mips_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    mips_fetch_stage_if.master  bus
);
    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        misalign_q, misalign_d;
    ifid_t       ifid_q, ifid_d;

    pc_incrementer u_pc_inc (
        .in1_i (pc_q),
        .in2_i (32'd4),
        .sum_o (pc_plus4)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ifid_d        = ifid_q;
        fetch_count_d = fetch_count_q;
        misalign_d    = misalign_q;
        if (state_q == ST_RUN) begin
            // Redirects beat halt and stall; a jump also masks the branch misalign check.
            if (bus.jump) begin
                pc_d   = jump_target(ifid_q.pc_plus4, bus.jump_index);
                ifid_d = IFID_BUBBLE;
            end else if (bus.branch_taken) begin
                pc_d   = {bus.branch_target[31:2], 2'b00};
                ifid_d = IFID_BUBBLE;
                if (bus.branch_target[1:0] != 2'b00) begin
                    misalign_d = 1'b1;
                end
            end else if (bus.halt_req) begin
                ifid_d  = IFID_BUBBLE;
                state_d = ST_HALTED;
            end else if (!bus.stall) begin
                pc_d          = pc_plus4;
                ifid_d        = '{pc_plus4: pc_plus4, instr: bus.imem_rdata, valid: 1'b1};
                fetch_count_d = fetch_count_q + 32'd1;
            end
        end else begin
            ifid_d = IFID_BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            ifid_q        <= IFID_BUBBLE;
            fetch_count_q <= 32'd0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_q        <= ifid_d;
            fetch_count_q <= fetch_count_d;
            misalign_q    <= misalign_d;
        end
    end

    assign bus.imem_addr     = pc_q;
    assign bus.ifid_pc_plus4 = ifid_q.pc_plus4;
    assign bus.ifid_instr    = ifid_q.instr;
    assign bus.ifid_valid    = ifid_q.valid;
    assign bus.fetch_count   = fetch_count_q;
    assign bus.halted        = (state_q == ST_HALTED);
    assign bus.misalign_err  = misalign_q;
endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage: directed plan with literal expectations, then random
// stimulus, all outputs compared each negedge against a behavioural model.
module tb_mips_fetch_stage;
    localparam logic [31:0] RPC = 32'h0040_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    mips_fetch_stage_if bus ();

    mips_fetch_stage #(.RESET_PC(RPC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    // Behavioural model state
    logic [31:0] m_pc, m_ppc4, m_instr, m_cnt;
    logic        m_valid, m_halted, m_mis;

    task automatic m_reset();
        m_pc = RPC; m_ppc4 = 0; m_instr = 0; m_valid = 0;
        m_cnt = 0; m_halted = 0; m_mis = 0;
    endtask

    task automatic m_bubble();
        m_ppc4 = 0; m_instr = 0; m_valid = 0;
    endtask

    task automatic model_edge();
        if (m_halted) begin
            m_bubble();
        end else if (bus.jump) begin
            m_pc = {m_ppc4[31:28], 28'(bus.jump_index) * 28'd4};
            m_bubble();
        end else if (bus.branch_taken) begin
            m_pc = bus.branch_target - (bus.branch_target % 32'd4);
            if (bus.branch_target % 32'd4 != 0) m_mis = 1;
            m_bubble();
        end else if (bus.halt_req) begin
            m_halted = 1;
            m_bubble();
        end else if (!bus.stall) begin
            m_instr = mem_word(m_pc);
            m_pc    = m_pc + 32'd4;
            m_ppc4  = m_pc;
            m_valid = 1;
            m_cnt   = m_cnt + 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("imem_addr",     bus.imem_addr,           m_pc);
        chk("ifid_pc_plus4", bus.ifid_pc_plus4,       m_ppc4);
        chk("ifid_instr",    bus.ifid_instr,          m_instr);
        chk("ifid_valid",    32'(bus.ifid_valid),     32'(m_valid));
        chk("fetch_count",   bus.fetch_count,         m_cnt);
        chk("halted",        32'(bus.halted),         32'(m_halted));
        chk("misalign_err",  32'(bus.misalign_err),   32'(m_mis));
    end

    task automatic idle();
        bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
        bus.jump = 0; bus.jump_index = 0; bus.halt_req = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Called 1 time unit after a posedge; the pulse ends well before the next negedge.
    task automatic rst_pulse();
        rst_n = 0;
        m_reset();
        #1;
        chk("rst_imem_addr", bus.imem_addr, RPC);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        #1 rst_n = 1;
    endtask

    initial begin
        idle();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_addr", bus.imem_addr, 32'h0040_0000);
        chk("reset_count", bus.fetch_count, 32'd0);
        rst_n = 1;

        // Sequential fetch
        cycle(); chk("seq1_pc4", bus.ifid_pc_plus4, 32'h0040_0004);
        chk("seq1_valid", 32'(bus.ifid_valid), 32'd1);
        cycle(); chk("seq2_pc4", bus.ifid_pc_plus4, 32'h0040_0008);

        // Stall holds everything
        bus.stall = 1;
        cycle(); cycle();
        chk("stall_addr", bus.imem_addr, 32'h0040_0008);
        chk("stall_pc4", bus.ifid_pc_plus4, 32'h0040_0008);
        chk("stall_count", bus.fetch_count, 32'd2);
        bus.stall = 0;
        cycle(); chk("seq3_pc4", bus.ifid_pc_plus4, 32'h0040_000C);
        chk("seq3_instr", bus.ifid_instr, mem_word(32'h0040_0008));
        chk("seq3_count", bus.fetch_count, 32'd3);

        // Branch overrides stall, one bubble
        bus.stall = 1; bus.branch_taken = 1; bus.branch_target = 32'h0040_0100;
        cycle(); chk("br_addr", bus.imem_addr, 32'h0040_0100);
        chk("br_bubble_valid", 32'(bus.ifid_valid), 32'd0);
        chk("br_bubble_instr", bus.ifid_instr, 32'd0);
        idle();
        cycle(); chk("br_tgt_pc4", bus.ifid_pc_plus4, 32'h0040_0104);

        // Jump beats a misaligned branch
        bus.branch_taken = 1; bus.branch_target = 32'h0040_000C;
        cycle(); idle();
        cycle(); chk("pre_jump_pc4", bus.ifid_pc_plus4, 32'h0040_0010);
        bus.jump = 1; bus.jump_index = 26'h000_0040;
        bus.branch_taken = 1; bus.branch_target = 32'h0040_0203;
        cycle(); chk("jump_addr", bus.imem_addr, 32'h0000_0100);
        chk("jump_mis", 32'(bus.misalign_err), 32'd0);
        idle();
        bus.branch_taken = 1; bus.branch_target = 32'h0040_0203;
        cycle(); chk("mis_addr", bus.imem_addr, 32'h0040_0200);
        chk("mis_err", 32'(bus.misalign_err), 32'd1);

        // PC wraparound
        bus.branch_target = 32'hFFFF_FFFC;
        cycle(); idle();
        cycle(); chk("wrap_pc4", bus.ifid_pc_plus4, 32'h0000_0000);
        chk("wrap_addr", bus.imem_addr, 32'h0000_0000);

        // Halt is absorbing
        bus.halt_req = 1;
        cycle(); idle();
        chk("halt_flag", 32'(bus.halted), 32'd1);
        bus.branch_taken = 1; bus.branch_target = 32'h0000_1000; bus.stall = 1;
        repeat (3) cycle();
        chk("halt_addr", bus.imem_addr, 32'h0000_0000);
        chk("halt_count", bus.fetch_count, 32'd6);
        chk("halt_valid", 32'(bus.ifid_valid), 32'd0);
        idle();
        rst_pulse();
        cycle(); chk("post_rst_pc4", bus.ifid_pc_plus4, 32'h0040_0004);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            bus.stall        = ($urandom % 4) == 0;
            bus.branch_taken = ($urandom % 8) == 0;
            bus.jump         = ($urandom % 12) == 0;
            bus.halt_req     = ($urandom % 100) == 0;
            bus.jump_index   = 26'($urandom);
            case ($urandom % 4)
                0: bus.branch_target = 32'hFFFF_FFFC;
                1: bus.branch_target = $urandom;
                default: bus.branch_target = RPC + (32'($urandom % 64) << 2);
            endcase
            if ((m_halted && ($urandom % 10) == 0) || ($urandom % 300) == 0) begin
                rst_pulse();
            end
            cycle();
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
